// File: rtl/muldiv_pkg.sv
// Shared constants and op decode for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int ITER     = MD_WIDTH;
  localparam logic [MD_WIDTH-1:0] DIV0_LO = '1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  typedef struct packed {
    logic iterative;  // goes through CALC/FIX
    logic is_div;     // divide datapath instead of multiply
    logic is_signed;  // magnitude conversion and sign fix-up needed
    logic wr_hi;      // single-cycle MTHI
    logic wr_lo;      // single-cycle MTLO
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_MULT:  begin d.iterative = 1'b1; d.is_signed = 1'b1; end
      OP_MULTU: begin d.iterative = 1'b1; end
      OP_DIV:   begin d.iterative = 1'b1; d.is_div = 1'b1; d.is_signed = 1'b1; end
      OP_DIVU:  begin d.iterative = 1'b1; d.is_div = 1'b1; end
      OP_MTHI:  d.wr_hi = 1'b1;
      OP_MTLO:  d.wr_lo = 1'b1;
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// acc_hi/acc_lo hold {partial product, remaining multiplier} for multiply and
// {partial remainder, dividend/quotient} for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Both candidate updates are formed every cycle; is_div picks one.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      // Partial remainder stays below the divisor, so bit WIDTH is the borrow.
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry-out of the add shifts into the top of the partial product.
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Iterative ops: start edge, 32 CALC edges, one FIX edge that writes HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Operands and sign information captured at the start edge
  logic             is_div;
  logic             neg_main;
  logic             neg_rem;
  logic             div_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  op_dec_t          dec;
  logic             take;
  logic             take_iter;
  logic             fix_write;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [2*WIDTH-1:0] prod;

  assign dec       = decode_op(bus.op);
  assign take      = (state == S_IDLE) && bus.start && !bus.flush;
  assign take_iter = take && dec.iterative;
  assign fix_write = (state == S_FIX) && !bus.flush;
  assign a_neg     = dec.is_signed && bus.a[WIDTH-1];
  assign b_neg     = dec.is_signed && bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Sign correction of the magnitude result, plus the divide-by-zero override
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_main) prod = -prod;
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = neg_rem  ? -acc_hi : acc_hi;
      res_lo = neg_main ? -acc_lo : acc_lo;
    end
  end

  // FSM, iteration counter and the one-cycle done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take_iter) begin
            state <= S_CALC;
            count <= '0;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state <= S_IDLE;
            count <= '0;
          end else if (count == LAST) begin
            state <= S_FIX;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          done  <= fix_write;
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Operand capture at the start edge, then one datapath step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      operand  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else if (take_iter) begin
      is_div   <= dec.is_div;
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= dec.is_div && (bus.b == '0);
      a_raw    <= bus.a;
      acc_hi   <= '0;
      acc_lo   <= dec.is_div ? a_mag : b_mag;
      operand  <= dec.is_div ? b_mag : a_mag;
    end else if (state == S_CALC) begin
      acc_hi   <= step_hi;
      acc_lo   <= step_lo;
    end
  end

  // Architectural HI/LO: written by MTHI/MTLO when idle or by an unflushed FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_write) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (take) begin
      if (dec.wr_hi) hi <= bus.a;
      if (dec.wr_lo) lo <= bus.a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with scoreboard plus
// hand-written sequences for MT writes, ignored starts, flush and async reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_cnt;
  res_t sb[$];
  vec_t vecs[11];

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int id);
    int   cyc;
    res_t r;
    r.hi = exp_hi; r.lo = exp_lo;
    sb.push_back(r);
    start_op(op, a, b);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: vector %0d got no done within 60 cycles", id);
      void'(sb.pop_front());
    end else begin
      r = sb.pop_front();
      chk("latency", 64'(cyc), 64'd33);
      chk("busy_at_done", 64'(bus.busy), 64'd0);
      chk("hi", 64'(bus.hi), 64'(r.hi));
      chk("lo", 64'(bus.lo), 64'(r.lo));
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h) cycles=%0d",
               id, op, a, b, bus.hi, bus.lo, r.hi, r.lo, cyc);
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int dcnt;
    checks = 0; errors = 0; done_cnt = 0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    rst_n = 1'b0;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_DIVU,  32'd1000,     32'd7,        32'd6,        32'd142};
    vecs[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[10] = '{OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, i);

    // MTHI then MTLO on consecutive cycles
    dcnt = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", 64'(bus.hi), 64'h12345678);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    bus.op = OP_MTLO; bus.a = 32'h9ABCDEF0;
    @(negedge clk);
    chk("mtlo_lo", 64'(bus.lo), 64'h9ABCDEF0);
    chk("mtlo_hi_held", 64'(bus.hi), 64'h12345678);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    $display("mt sequence hi=%h lo=%h", bus.hi, bus.lo);
    // Ops 6 and 7 do nothing
    bus.op = 3'd6; bus.a = 32'h0BADF00D;
    @(negedge clk);
    bus.op = 3'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("op67_hi", 64'(bus.hi), 64'h12345678);
    chk("op67_lo", 64'(bus.lo), 64'h9ABCDEF0);
    chk("op67_busy", 64'(bus.busy), 64'd0);
    chk("mt_no_done", 64'(done_cnt - dcnt), 64'd0);

    // MULTU, ignored DIVU start at cycle 5, flush at cycle 10
    dcnt = done_cnt;
    start_op(OP_MULTU, 32'd5, 32'd5);
    for (int c = 1; c <= 11; c++) begin
      bus.start = (c == 5); bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd3;
      bus.flush = (c == 10);
      @(negedge clk);
      if (c == 6) chk("busy_after_ignored_start", 64'(bus.busy), 64'd1);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_idle", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_no_done", 64'(done_cnt - dcnt), 64'd0);
    chk("flush_busy_stays_low", 64'(bus.busy), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'h12345678);
    chk("flush_lo", 64'(bus.lo), 64'h9ABCDEF0);
    $display("flush mid-op hi=%h lo=%h", bus.hi, bus.lo);

    // flush together with start while idle: start ignored
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEADBEEF;
    @(negedge clk);
    bus.op = OP_MULTU;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_hi", 64'(bus.hi), 64'h12345678);
    chk("flush_start_busy", 64'(bus.busy), 64'd0);

    // flush landing on the FIX cycle
    dcnt = done_cnt;
    start_op(OP_MULTU, 32'd3, 32'd3);
    repeat (32) @(negedge clk);
    chk("fix_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fix_flush_done", 64'(bus.done), 64'd0);
    chk("fix_flush_busy", 64'(bus.busy), 64'd0);
    chk("fix_flush_hi", 64'(bus.hi), 64'h12345678);
    chk("fix_flush_lo", 64'(bus.lo), 64'h9ABCDEF0);
    repeat (3) @(negedge clk);
    chk("fix_flush_no_done", 64'(done_cnt - dcnt), 64'd0);
    $display("flush in FIX hi=%h lo=%h", bus.hi, bus.lo);

    // Async reset mid-DIVU at cycle 20
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", 64'(bus.busy), 64'd0);
    chk("areset_done", 64'(bus.done), 64'd0);
    chk("areset_hi", 64'(bus.hi), 64'd0);
    chk("areset_lo", 64'(bus.lo), 64'd0);
    $display("async reset mid-divide busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 100);

    // Random operands against a behavioural model
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      logic [63:0] p;
      int sa, sq, sr;
      ra = $urandom; rb = $urandom;
      if (rb == 0) rb = 32'd1;
      if (ra == 32'h80000000) ra = 32'd1;
      case (i % 4)
        0: begin p = {32'd0, ra} * {32'd0, rb}; run_op(OP_MULTU, ra, rb, p[63:32], p[31:0], 200 + i); end
        1: begin p = 64'(longint'(signed'(ra)) * longint'(signed'(rb)));
                 run_op(OP_MULT, ra, rb, p[63:32], p[31:0], 200 + i); end
        2: run_op(OP_DIVU, ra, rb, ra % rb, ra / rb, 200 + i);
        default: begin
          sa = signed'(ra);
          sq = sa / signed'(rb); sr = sa % signed'(rb);
          run_op(OP_DIV, ra, rb, 32'(sr), 32'(sq), 200 + i);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
